// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/multu/div/divu sequencer that produces the HI/LO results.
// Optional macro MD_FAST_MULT_EN: mult/multu use a single-cycle combinational product.
module md_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        hilo_write,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    // Multiply: {partial product, multiplier}. Divide: quotient/dividend shifts through [31:0].
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        isDiv_q, isDiv_d;
    logic        negRes_q, negRes_d;
    logic        negRem_q, negRem_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        isSigned;
    logic [31:0] aMag, bMag;
    logic [32:0] multSum;
    logic [32:0] remShift, remTrial;
    logic [63:0] prodFix;
    logic [31:0] quoFix, remFix;
`ifdef MD_FAST_MULT_EN
    logic [63:0] fastProd;
    assign fastProd = {32'd0, aMag} * {32'd0, bMag};
`endif

    assign isSigned = ~op[0];
    assign aMag     = (isSigned && a[31]) ? (~a + 32'd1) : a;
    assign bMag     = (isSigned && b[31]) ? (~b + 32'd1) : b;
    assign multSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, divisor_q} : 33'd0);
    assign remShift = {rem_q, acc_q[31]};
    assign remTrial = remShift - {1'b0, divisor_q};
    assign prodFix  = negRes_q ? (~acc_q + 64'd1) : acc_q;
    assign quoFix   = negRes_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign remFix   = negRem_q ? (~rem_q + 32'd1) : rem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            rem_q     <= 32'd0;
            divisor_q <= 32'd0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    isDiv_d   = op[1];
                    negRes_d  = isSigned & (a[31] ^ b[31]);
                    negRem_d  = isSigned & a[31];
                    count_d   = 5'd0;
                    rem_d     = 32'd0;
                    divisor_d = op[1] ? bMag : aMag;
                    acc_d     = {32'd0, op[1] ? aMag : bMag};
                    div0_d    = 1'b0;
                    if (op[1] && (b == 32'd0)) begin
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end
`ifdef MD_FAST_MULT_EN
                    else if (!op[1]) begin
                        acc_d   = fastProd;
                        state_d = FIX;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                count_d = count_q + 5'd1;
                if (isDiv_q) begin
                    // Restoring step: keep the trial difference only when it did not go negative.
                    if (!remTrial[32]) begin
                        rem_d = remTrial[31:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
                    end else begin
                        rem_d = remShift[31:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {multSum, acc_q[31:1]};
                end
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = quoFix;
                    hi_d = remFix;
                end else begin
                    hi_d = prodFix[63:32];
                    lo_d = prodFix[31:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign div0       = done & div0_q;
    assign hilo_write = done & ~div0_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases plus randomized ops checked
// against an arithmetic reference model of the mult/div results, latency and HI/LO behaviour.
module tb_md_sequencer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic        hilo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    int testsRun = 0;
    int failCount = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

`ifdef MD_FAST_MULT_EN
    localparam int MULT_LAT = 2;
`else
    localparam int MULT_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    md_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .div0(div0),
        .hilo_write(hilo_write),
        .hi(hi),
        .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against the bench's expectation and tallies the result.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each instruction.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] pHi, input logic [31:0] pLo,
                                  output logic [31:0] eHi, output logic [31:0] eLo,
                                  output logic eD0, output int eLat);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eD0 = 1'b0;
        if (o[1] && y == 32'd0) begin
            eD0 = 1'b1; eHi = pHi; eLo = pLo; eLat = 1;
        end else if (!o[1]) begin
            if (o[0]) p = {32'd0, x} * {32'd0, y};
            else      p = 64'(sx * sy);
            eHi = p[63:32]; eLo = p[31:0]; eLat = MULT_LAT;
        end else begin
            if (o[0]) begin
                q = longint'({32'd0, x}) / longint'({32'd0, y});
                r = longint'({32'd0, x}) % longint'({32'd0, y});
            end else begin
                q = sx / sy;
                r = sx % sy;
            end
            eLo = q[31:0]; eHi = r[31:0]; eLat = DIV_LAT;
        end
    endfunction

    // Called at a negedge: presents one start (cycle 0) and waits, bounded, for done.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input int pulseA, input int pulseB,
                                 output int doneCyc, output logic hw, output logic d0,
                                 output logic bsy1);
        op = o; a = x; b = y; start = 1'b1;
        doneCyc = -1; hw = 1'b0; d0 = 1'b0; bsy1 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == pulseA) || (c == pulseB);
            if (start) begin
                op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end
            if (c == 1) bsy1 = busy;
            if (done === 1'b1) begin
                doneCyc = c; hw = hilo_write; d0 = div0;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input int pulseA, input int pulseB);
        logic [31:0] eHi, eLo;
        logic eD0, hw, d0, bsy1;
        int eLat, doneCyc;
        model(o, x, y, modelHi, modelLo, eHi, eLo, eD0, eLat);
        applyStimulus(o, x, y, pulseA, pulseB, doneCyc, hw, d0, bsy1);
        checkOutput({tag, ".latency"}, 64'(doneCyc), 64'(eLat));
        checkOutput({tag, ".busy"}, 64'(bsy1), 64'd1);
        checkOutput({tag, ".div0"}, 64'(d0), 64'(eD0));
        checkOutput({tag, ".hilo_write"}, 64'(hw), 64'(!eD0));
        checkOutput({tag, ".hi"}, 64'(hi), 64'(eHi));
        checkOutput({tag, ".lo"}, 64'(lo), 64'(eLo));
        modelHi = eHi;
        modelLo = eLo;
    endtask

    initial begin
        int events;
        logic [1:0]  rOp;
        logic [31:0] rA, rB;
        reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.div0", 64'(div0), 64'd0);
        checkOutput("reset.hilo_write", 64'(hilo_write), 64'd0);
        checkOutput("reset.hi", 64'(hi), 64'd0);
        checkOutput("reset.lo", 64'(lo), 64'd0);

        // Release reset and start in the same cycle: the very next edge must accept it.
        @(negedge clk);
        reset = 1'b1;
        runAndCheck("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
        checkOutput("multu_max.hi_const", 64'(hi), 64'hFFFFFFFE);
        checkOutput("multu_max.lo_const", 64'(lo), 64'h00000001);
        @(negedge clk);
        runAndCheck("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, -1, -1);
        checkOutput("mult_neg.lo_const", 64'(lo), 64'hFFFFFFEB);
        @(negedge clk);
        runAndCheck("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, -1, -1);
        checkOutput("div_neg.lo_const", 64'(lo), 64'hFFFFFFFD);
        @(negedge clk);
        runAndCheck("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1);
        checkOutput("div_ovf.lo_const", 64'(lo), 64'h80000000);
        @(negedge clk);
        runAndCheck("preload", 2'b11, 32'h56781234, 32'h00010000, -1, -1);
        @(negedge clk);
        runAndCheck("divu_by0", 2'b11, 32'd100, 32'd0, -1, -1);
        checkOutput("divu_by0.hi_const", 64'(hi), 64'h1234);
        checkOutput("divu_by0.lo_const", 64'(lo), 64'h5678);

        // Starts in cycles 5 and 34 are ignored; a start in cycle 35 is accepted.
        @(negedge clk);
        runAndCheck("ignore_start", 2'b01, 32'h0000BEEF, 32'h00012345, 5, 34);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore_start.idle_busy", 64'(busy), 64'd0);
        checkOutput("ignore_start.idle_done", 64'(done), 64'd0);
        runAndCheck("restart35", 2'b10, 32'd1000, 32'hFFFFFFF3, -1, -1);

        for (int i = 0; i < 20; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 15));
                2:       rB = 32'hFFFFFFFF;
                default: rB = $urandom;
            endcase
            @(negedge clk);
            runAndCheck($sformatf("rand%0d", i), rOp, rA, rB, -1, -1);
        end

        // Reset in cycle 10 of a divu aborts it without writing HI/LO.
        @(negedge clk);
        runAndCheck("pre_abort", 2'b00, 32'hFFFFFFFD, 32'd7, -1, -1);
        @(negedge clk);
        op = 2'b11; a = 32'd12345; b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        checkOutput("abort.busy", 64'(busy), 64'd0);
        checkOutput("abort.hi", 64'(hi), 64'd0);
        checkOutput("abort.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        events = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || hilo_write === 1'b1) events++;
        end
        checkOutput("abort.no_done", 64'(events), 64'd0);
        checkOutput("abort.idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
